// File: rtl/cond_logic.sv
// Condition-check stage after the ALU: holds the NZCV status register,
// evaluates the ARM condition field and gates the decoder's write strobes.
module cond_logic #(
    parameter logic [3:0] FLAG_RESET   = 4'b0000,
    parameter bit         COND_NV_EXEC = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       Stall,
    output logic [3:0] Flags,
    output logic       CondEx,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite
);

    logic [3:0] r_flags;
    logic       w_n;
    logic       w_z;
    logic       w_c;
    logic       w_v;
    logic       w_ge;
    logic       w_condEx;
    logic       w_flagEn;

    assign w_n  = r_flags[3];
    assign w_z  = r_flags[2];
    assign w_c  = r_flags[1];
    assign w_v  = r_flags[0];
    assign w_ge = (w_n == w_v);

    // Evaluated on the registered flags so an instruction never sees its own result.
    always_comb begin
        w_condEx = 1'b0;
        case (Cond)
            4'b0000: w_condEx = w_z;
            4'b0001: w_condEx = ~w_z;
            4'b0010: w_condEx = w_c;
            4'b0011: w_condEx = ~w_c;
            4'b0100: w_condEx = w_n;
            4'b0101: w_condEx = ~w_n;
            4'b0110: w_condEx = w_v;
            4'b0111: w_condEx = ~w_v;
            4'b1000: w_condEx = w_c & ~w_z;
            4'b1001: w_condEx = ~w_c | w_z;
            4'b1010: w_condEx = w_ge;
            4'b1011: w_condEx = ~w_ge;
            4'b1100: w_condEx = ~w_z & w_ge;
            4'b1101: w_condEx = w_z | ~w_ge;
            4'b1110: w_condEx = 1'b1;
            4'b1111: w_condEx = COND_NV_EXEC;
            default: w_condEx = 1'b0;
        endcase
    end

    assign w_flagEn = w_condEx & ~Stall;

    // N,Z and C,V halves update independently; a stalled update is simply re-presented later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= FLAG_RESET;
        end else begin
            if (w_flagEn && FlagW[1]) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (w_flagEn && FlagW[0]) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign Flags    = r_flags;
    assign CondEx   = w_condEx;
    assign PCSrc    = PCS & w_condEx;
    assign RegWrite = RegW & w_condEx & ~NoWrite;
    assign MemWrite = MemW & w_condEx;

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Stage directly downstream of the 32-bit ALU in the ARM datapath.
- Holds the architectural NZCV status register and captures the ALU's 4-bit flag vector {N,Z,C,V} under decoder-controlled write enables.
- Evaluates the instruction's 4-bit ARM condition field against the current, pre-update flags.
- Gates the decoder's PCS/RegW/MemW strobes so a failed condition commits nothing.

Parameters:
FLAG_RESET, 4'b0000, value loaded into the NZCV register on reset, ordered {N,Z,C,V}
COND_NV_EXEC, 1, CondEx value for Cond=4'b1111: 1 = execute as AL, 0 = never execute

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
Cond  input  4  instruction condition field, bits [31:28]
ALUFlags  input  4  flags from ALU this cycle: [3]=N, [2]=Z, [1]=C, [0]=V
FlagW  input  2  decoder flag-write request: [1] updates N,Z; [0] updates C,V
PCS  input  1  decoder: instruction writes PC
RegW  input  1  decoder: instruction writes register file
MemW  input  1  decoder: instruction writes memory
NoWrite  input  1  decoder: compare-class op (CMP/CMN/TST/TEQ); suppresses RegWrite
Stall  input  1  pipeline hold; blocks the flag update this cycle
Flags  output  4  current architectural NZCV register, {N,Z,C,V}
CondEx  output  1  condition passed, evaluated on Flags (pre-update)
PCSrc  output  1  PCS & CondEx
RegWrite  output  1  RegW & CondEx & ~NoWrite
MemWrite  output  1  MemW & CondEx

Behaviour:
Reset:
- rst_n low -> Flags = FLAG_RESET immediately (asynchronous), independent of clk.
- Release is sampled at the next rising edge; no flag update happens in the cycle rst_n deasserts.
- Reset asserted mid-instruction discards any pending update.

CondEx:
- Combinational from Cond and the registered Flags, never from ALUFlags.
- Zero-cycle latency to PCSrc, RegWrite and MemWrite.
- Condition table, with N,Z,C,V taken from Flags:
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 CS: C
  - 0011 CC: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: ~Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: COND_NV_EXEC

Flag update at rising clk edge:
- Update enable is CondEx & ~Stall.
- FlagW[1] set with enable -> Flags[3:2] <= ALUFlags[3:2].
- FlagW[0] set with enable -> Flags[1:0] <= ALUFlags[1:0].
- The two halves are independent: FlagW=10 keeps C,V; FlagW=01 keeps N,Z.
- Otherwise Flags holds.

Flag values:
- C is whatever the ALU supplies (currently always 0); this block does not regenerate or correct it.
- No X propagation: unknown FlagW is treated as 00 in simulation assertions (bench flags it as an error).

Simultaneous events:
- A flag-setting instruction sees the old flags for its own condition; the new flags are visible to the next instruction only.
- Stall with FlagW nonzero: the update is deferred. The decoder re-presents the same inputs on the next cycle; no internal pending state is kept.
- A failed condition with FlagW nonzero leaves Flags unchanged.

Test Plan:
- Assert rst_n=0 mid-cycle with Flags=1111 -> Flags=0000 before the next clk edge; hold reset, toggle clk -> Flags stays 0000.
- ALUFlags=0100, FlagW=11, Cond=1110 -> next cycle Flags=0100. Then Cond=0000 (EQ), RegW=1 -> CondEx=1, RegWrite=1. Then Cond=0001 (NE) -> CondEx=0, RegWrite=0, MemWrite=0, PCSrc=0.
- Flags=1001, ALUFlags=0110, FlagW=10 -> Flags=0101 (C,V kept). Then FlagW=01, ALUFlags=1010 -> Flags=0110.
- Cycle through all 16 Cond codes against all 16 Flags values -> CondEx matches the table (256 checks). Spot checks:
  - GE with N=1,V=1 -> 1
  - GT with Z=1 -> 0
  - HI with C=1,Z=0 -> 1
- Stall=1, FlagW=11, ALUFlags=1111 -> Flags unchanged. Deassert Stall -> Flags=1111 one edge later.
- Cond=0000 with Z=0, FlagW=11, ALUFlags=0100 -> Flags unchanged.
- NoWrite=1, RegW=1, Cond=AL, FlagW=11 (CMP) -> RegWrite=0 and flags update.
